ch3_wave_sequencer: RTL



---
 rtl/ch3_wave_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/ch3_wave_sequencer.sv
// Channel 3 playback-position sequencer: frequency timer, sample index, wave RAM
// read strobe/nibble select, and the CPU/playback wave RAM address mux.
module ch3_wave_sequencer #(
   parameter int unsigned FREQ_W = 11,
   parameter int unsigned IDX_W  = 5
) (
   input  logic              amuk_4mhz,
   input  logic              apu_reset,
   input  logic              ch3_dac_en,
   input  logic [FREQ_W-1:0] ch3_freq,
   input  logic              ch3_trigger,
   input  logic [IDX_W-2:0]  cpu_addr,
   output logic              ch3_active,
   output logic              efar_q,
   output logic [IDX_W-2:0]  wave_ram_addr,
   output logic              wave_rd_strobe,
   output logic [IDX_W-1:0]  sample_idx
);

   localparam logic [FREQ_W-1:0] TIMER_MAX = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   state_t              r_state;
   logic                r_phase;
   logic [FREQ_W-1:0]   r_timer;
   logic [IDX_W-1:0]    r_idx;
   logic                r_strobe;

   state_t              w_state_nxt;
   logic                w_phase_nxt;
   logic [FREQ_W-1:0]   w_timer_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                w_strobe_nxt;

   // Next-state: dac off beats trigger, trigger beats a coincident overflow
   always_comb begin
      w_state_nxt  = r_state;
      w_phase_nxt  = r_phase;
      w_timer_nxt  = r_timer;
      w_idx_nxt    = r_idx;
      w_strobe_nxt = 1'b0;

      if (!ch3_dac_en) begin
         w_state_nxt = ST_IDLE;
      end else if (ch3_trigger) begin
         w_state_nxt = ST_PLAY;
         w_timer_nxt = ch3_freq;
         w_phase_nxt = 1'b0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            ST_PLAY: begin
               w_phase_nxt = ~r_phase;
               // Timer only moves on odd phases: 2 MHz tick from the 4 MHz clock
               if (r_phase) begin
                  if (r_timer == TIMER_MAX) begin
                     w_timer_nxt  = ch3_freq;
                     w_idx_nxt    = r_idx + IDX_W'(1);
                     w_strobe_nxt = 1'b1;
                  end else begin
                     w_timer_nxt = r_timer + FREQ_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge amuk_4mhz) begin
      if (apu_reset) begin
         r_state  <= ST_IDLE;
         r_phase  <= 1'b0;
         r_timer  <= '0;
         r_idx    <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_phase  <= w_phase_nxt;
         r_timer  <= w_timer_nxt;
         r_idx    <= w_idx_nxt;
         r_strobe <= w_strobe_nxt;
      end
   end

   assign ch3_active     = (r_state == ST_PLAY);
   assign efar_q         = r_idx[0];
   assign sample_idx     = r_idx;
   assign wave_rd_strobe = r_strobe;

   // While playing, CPU FF3x accesses land on the byte currently being played
   assign wave_ram_addr  = ch3_active ? r_idx[IDX_W-1:1] : cpu_addr;

endmodule
